// File: rtl/cmp_mem_arbiter_if.sv
// Node and memory-port bundle for the shared data-memory arbiter.
// slave = arbiter side, master = nodes plus memory macro.
interface cmp_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [0:3]          req;
    logic [0:3]          wr;
    logic [0:4*ADDR_W-1] addr;
    logic [0:4*DATA_W-1] wdata;
    logic [0:3]          ack;
    logic [0:DATA_W-1]   rdata;
    logic [0:1]          grant_id;
    logic                busy;
    logic                mem_en;
    logic                mem_wr_en;
    logic [0:ADDR_W-1]   mem_addr;
    logic [0:DATA_W-1]   mem_d_out;
    logic [0:DATA_W-1]   mem_d_in;

    modport slave (
        input  req, wr, addr, wdata, mem_d_in,
        output ack, rdata, grant_id, busy,
        output mem_en, mem_wr_en, mem_addr, mem_d_out
    );

    modport master (
        output req, wr, addr, wdata, mem_d_in,
        input  ack, rdata, grant_id, busy,
        input  mem_en, mem_wr_en, mem_addr, mem_d_out
    );
endinterface

// File: rtl/cmp_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between
// the four cardinal CMP nodes, with a registered memory port.
module cmp_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input logic              clk,
    input logic              reset,
    cmp_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]        ptr;
    logic [1:0]        grant_id;
    logic [1:0]        win;
    logic [1:0]        idx;
    logic              hit;
    logic [2:0]        cnt;
    logic              mem_en;
    logic              mem_wr_en;
    logic [0:ADDR_W-1] mem_addr;
    logic [0:DATA_W-1] mem_d_out;
    logic [0:DATA_W-1] rdata;

    logic [0:ADDR_W-1] addr_n  [4];
    logic [0:DATA_W-1] wdata_n [4];

    for (genvar i = 0; i < 4; i++) begin : g_node
        assign addr_n[i]  = bus.addr[i*ADDR_W +: ADDR_W];
        assign wdata_n[i] = bus.wdata[i*DATA_W +: DATA_W];
    end

    // Scan from ptr+3 down to ptr so the nearest requester at/after ptr wins.
    always_comb begin
        hit = 1'b0;
        win = ptr;
        idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (bus.req[idx]) begin
                hit = 1'b1;
                win = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (hit) state_nxt = ACCESS;
            ACCESS:  state_nxt = mem_wr_en ? RESP : WAIT;
            WAIT:    if (cnt == 3'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr       <= 2'd0;
            grant_id  <= 2'd0;
            cnt       <= 3'd0;
            mem_en    <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_d_out <= '0;
            rdata     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        grant_id  <= win;
                        mem_en    <= 1'b1;
                        mem_wr_en <= bus.wr[win];
                        mem_addr  <= addr_n[win];
                        mem_d_out <= wdata_n[win];
                    end
                end
                ACCESS: begin
                    mem_en    <= 1'b0;
                    mem_wr_en <= 1'b0;
                    cnt       <= 3'(MEM_LAT - 1);
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        rdata <= bus.mem_d_in;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    ptr <= grant_id + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.ack = 4'b0000;
        if (state == RESP) begin
            bus.ack[grant_id] = 1'b1;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.grant_id  = grant_id;
    assign bus.rdata     = rdata;
    assign bus.mem_en    = mem_en;
    assign bus.mem_wr_en = mem_wr_en;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_d_out = mem_d_out;

endmodule

// File: tb/tb_cmp_mem_arbiter.sv
// Directed bench for cmp_mem_arbiter: one instance at read latency 1,
// one at latency 4, each with its own small memory model.
module tb_cmp_mem_arbiter;

    localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   order[$];

    always #5 clk = ~clk;

    cmp_mem_arbiter_if #(.ADDR_W(32), .DATA_W(64)) ia ();
    cmp_mem_arbiter_if #(.ADDR_W(32), .DATA_W(64)) ib ();

    cmp_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia)
    );

    cmp_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib)
    );

    // Memory A: real storage, read data valid only one cycle after mem_en.
    logic [63:0] mem_a [256];
    logic [63:0] pa;
    always @(posedge clk) begin
        if (ia.mem_en && ia.mem_wr_en)
            mem_a[ia.mem_addr[24:31]] <= ia.mem_d_out;
        pa <= (ia.mem_en && !ia.mem_wr_en) ? mem_a[ia.mem_addr[24:31]] : BAD;
    end
    assign ia.mem_d_in = pa;

    // Memory B: returns {addr, ~addr}, valid only four cycles after mem_en.
    logic [63:0] pb [4];
    always @(posedge clk) begin
        pb[0] <= (ib.mem_en && !ib.mem_wr_en) ? {ib.mem_addr, ~ib.mem_addr} : BAD;
        for (int i = 1; i < 4; i++) pb[i] <= pb[i-1];
    end
    assign ib.mem_d_in = pb[3];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic collect_a(input int n, input bit keep);
        int cyc;
        cyc = 0;
        order.delete();
        while (order.size() < n && cyc < 60) begin
            tick();
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (ia.ack[i]) begin
                    order.push_back(i);
                    if (!keep) ia.req[i] = 1'b0;
                end
            end
        end
        check("collect_count", 64'(order.size()), 64'(n));
    endtask

    task automatic check_order(input string tag, input int exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            check(tag, (i < order.size()) ? 64'(order[i]) : 64'hFFFF,
                  64'(exp[i]));
        end
    endtask

    initial begin
        int seen;
        reset = 1'b0;
        ia.req = '0; ia.wr = '0; ia.addr = '0; ia.wdata = '0;
        ib.req = '0; ib.wr = '0; ib.addr = '0; ib.wdata = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        check("rst_busy", 64'(ia.busy), 0);
        check("rst_ack", 64'(ia.ack), 0);
        check("rst_rdata", ia.rdata, 0);
        check("rst_mem_en", 64'(ia.mem_en), 0);
        check("rst_grant", 64'(ia.grant_id), 0);
        check("rst_mem_addr", 64'(ia.mem_addr), 0);

        // Node 2 write
        ia.req[2] = 1'b1;
        ia.wr[2] = 1'b1;
        ia.addr[64 +: 32] = 32'h10;
        ia.wdata[128 +: 64] = 64'hDEADBEEF_00000001;
        tick();
        check("wr_mem_en", 64'(ia.mem_en), 1);
        check("wr_mem_wr_en", 64'(ia.mem_wr_en), 1);
        check("wr_mem_addr", 64'(ia.mem_addr), 64'h10);
        check("wr_mem_d_out", ia.mem_d_out, 64'hDEADBEEF_00000001);
        check("wr_grant", 64'(ia.grant_id), 2);
        check("wr_ack_c1", 64'(ia.ack), 0);
        tick();
        check("wr_ack_c2", 64'(ia.ack), 4'b0010);
        check("wr_rdata", ia.rdata, 0);
        check("wr_busy_c2", 64'(ia.busy), 1);
        ia.req[2] = 1'b0;
        ia.wr[2] = 1'b0;
        tick();
        check("wr_idle_busy", 64'(ia.busy), 0);

        // Node 1 read back, latency 1
        ia.req[1] = 1'b1;
        ia.addr[32 +: 32] = 32'h10;
        tick();
        check("rd_mem_en", 64'(ia.mem_en), 1);
        check("rd_wr_en_c1", 64'(ia.mem_wr_en), 0);
        check("rd_grant", 64'(ia.grant_id), 1);
        tick();
        check("rd_ack_c2", 64'(ia.ack), 0);
        check("rd_wr_en_c2", 64'(ia.mem_wr_en), 0);
        check("rd_mem_en_c2", 64'(ia.mem_en), 0);
        check("rd_addr_hold", 64'(ia.mem_addr), 64'h10);
        tick();
        check("rd_ack_c3", 64'(ia.ack), 4'b0100);
        check("rd_rdata", ia.rdata, 64'hDEADBEEF_00000001);
        check("rd_wr_en_c3", 64'(ia.mem_wr_en), 0);
        ia.req[1] = 1'b0;
        tick();

        // Fairness from reset, all four holding requests
        reset = 1'b0;
        tick();
        reset = 1'b1;
        ia.wr = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            ia.addr[i*32 +: 32] = 32'h80 + 32'(i);
            ia.wdata[i*64 +: 64] = 64'(i);
        end
        ia.req = 4'b1111;
        collect_a(6, 1'b1);
        ia.req = 4'b0000;
        check_order("rr_order", '{0, 1, 2, 3, 0, 1});
        repeat (2) tick();
        check("rr_idle", 64'(ia.busy), 0);

        // Grant to node 3, then nodes 0 and 2 together: wrap gives node 0
        ia.req[3] = 1'b1;
        tick();
        check("wrap_grant3", 64'(ia.grant_id), 3);
        ia.req[0] = 1'b1;
        ia.req[2] = 1'b1;
        order.delete();
        collect_a(3, 1'b0);
        check_order("wrap_order", '{3, 0, 2});
        tick();

        // Latency-4 read on instance B
        ib.req[0] = 1'b1;
        ib.addr[0 +: 32] = 32'h20;
        tick();
        check("l4_mem_en", 64'(ib.mem_en), 1);
        check("l4_wr_en", 64'(ib.mem_wr_en), 0);
        check("l4_busy_c1", 64'(ib.busy), 1);
        for (int c = 2; c <= 5; c++) begin
            tick();
            check("l4_wait_ack", 64'(ib.ack), 0);
            check("l4_wait_busy", 64'(ib.busy), 1);
        end
        tick();
        check("l4_ack_c6", 64'(ib.ack), 4'b1000);
        check("l4_rdata", ib.rdata, 64'h00000020_FFFFFFDF);
        check("l4_busy_c6", 64'(ib.busy), 1);
        ib.req[0] = 1'b0;
        tick();
        check("l4_busy_c7", 64'(ib.busy), 0);
        check("l4_ack_c7", 64'(ib.ack), 0);

        // Reset while node 2's read sits in WAIT
        ib.req[2] = 1'b1;
        ib.addr[64 +: 32] = 32'h30;
        tick();
        tick();
        check("ab_busy_wait", 64'(ib.busy), 1);
        reset = 1'b0;
        tick();
        check("ab_busy", 64'(ib.busy), 0);
        check("ab_ack", 64'(ib.ack), 0);
        check("ab_rdata", ib.rdata, 0);
        check("ab_mem_en", 64'(ib.mem_en), 0);
        check("ab_mem_wr_en", 64'(ib.mem_wr_en), 0);
        check("ab_mem_addr", 64'(ib.mem_addr), 0);
        check("ab_mem_d_out", ib.mem_d_out, 0);
        check("ab_grant", 64'(ib.grant_id), 0);
        ib.req[2] = 1'b0;
        reset = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (ib.ack != 4'b0000) seen++;
        end
        check("ab_no_ack", 64'(seen), 0);

        ib.req[1] = 1'b1;
        ib.addr[32 +: 32] = 32'h40;
        tick();
        check("post_grant", 64'(ib.grant_id), 1);
        check("post_mem_addr", 64'(ib.mem_addr), 64'h40);
        repeat (4) tick();
        tick();
        check("post_ack", 64'(ib.ack), 4'b0100);
        check("post_rdata", ib.rdata, 64'h00000040_FFFFFFBF);
        ib.req[1] = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp_mem_arbiter.md
# cmp_mem_arbiter

Round-robin arbiter that shares one single-port data memory between the four CPU nodes of the cardinal CMP. Each node presents a held request (read or write, 32-bit address, 64-bit data) and receives a one-cycle acknowledge, plus read data for reads. The arbiter sequences each access through a small FSM, drives the shared memory port from registers and tolerates a parameterised memory read latency. It sits between the four cardinal_cpu data-memory ports and the shared memory macro.

## Interface
- ADDR_W, 32, address width per node
- DATA_W, 64, data width
- MEM_LAT, 1, memory read latency in cycles after the mem_en cycle (legal 1..7)
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- req  input  [0:3]  bit i = node i request; held until ack
- wr  input  [0:3]  bit i = node i request is a write
- addr  input  [0:4*ADDR_W-1]  node i address in bits [i*ADDR_W : i*ADDR_W+ADDR_W-1]
- wdata  input  [0:4*DATA_W-1]  node i write data, same slicing
- ack  output  [0:3]  one-hot, one-cycle completion pulse
- rdata  output  [0:DATA_W-1]  read data, valid in ack cycle of a read
- grant_id  output  [0:1]  node currently owning the memory
- busy  output  1  high in any state other than IDLE
- mem_en  output  1  memory enable
- mem_wr_en  output  1  memory write enable
- mem_addr  output  [0:ADDR_W-1]  memory address
- mem_d_out  output  [0:DATA_W-1]  memory write data
- mem_d_in  input  [0:DATA_W-1]  memory read data

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: if any req bit set, pick winner = first set bit searching from ptr upward with wrap 3->0; register winner into grant_id, its wr/addr/wdata into mem_wr_en/mem_addr/mem_d_out, set mem_en; go ACCESS. No request: stay IDLE.
- ACCESS: memory port active this cycle. Next edge clears mem_en and mem_wr_en. Write -> RESP. Read -> WAIT, latency counter loaded with MEM_LAT-1.
- WAIT: counter decrements each cycle; when counter = 0, capture mem_d_in into rdata, go RESP.
- RESP: ack[grant_id] = 1 for exactly this cycle; ptr <= (grant_id+1) mod 4; next state IDLE. No arbitration in RESP.
- Requester rule: req, wr, addr, wdata stable from assertion until ack cycle; req deasserted at the edge ending the ack cycle. Operands are sampled only in IDLE; later changes are ignored.
- Requester dropping req before ack: transaction still completes and ack still pulses.
- rdata holds last captured read value; unchanged by writes.
- mem_addr/mem_d_out hold last values outside ACCESS; only mem_en/mem_wr_en qualify them.
- Reset (reset = 0 at a rising edge): state IDLE, ptr = 0, grant_id = 0, ack = 0, rdata = 0, busy = 0, mem_en = 0, mem_wr_en = 0, mem_addr = 0, mem_d_out = 0. Reset mid-transaction aborts it: no ack is issued; a write already in ACCESS may have reached memory.

## Timing
- Request seen in IDLE at cycle 0: mem_en high in cycle 1.
- Write: ack in cycle 2 (3 cycles request-to-ack).
- Read: mem_d_in sampled in cycle 1+MEM_LAT, ack + rdata valid in cycle 2+MEM_LAT.
- Back-to-back: next IDLE arbitration at cycle after RESP. Sustained write throughput = 1 per 3 cycles. Sustained read throughput = 1 per 3+MEM_LAT cycles.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0…; max wait = 3 other transactions.
- busy = 1 in cycles 1..RESP inclusive, 0 in IDLE.

## Test plan
- Reset, then node 2 writes addr 0x10, data 0xDEADBEEF_00000001 -> mem_en = mem_wr_en = 1 in cycle 1 with those values; ack = 0010 in cycle 2; rdata stays 0.
- MEM_LAT = 1, node 1 reads 0x10, memory model returns 0xDEADBEEF_00000001 -> ack = 0100 in cycle 3 with rdata equal to that value; mem_wr_en = 0 throughout.
- All four nodes request simultaneously from reset and re-request after each ack -> ack order 0,1,2,3,0,1; no node acked twice before others.
- After grant to node 3, nodes 0 and 2 request together -> node 0 wins (wrap), then node 2.
- MEM_LAT = 4 read -> mem_d_in captured in cycle 5, ack in cycle 6; busy high cycles 1..6.
- reset = 0 asserted in WAIT of a read -> next cycle all outputs at reset values, no ack ever issued for that read; a new request from node 1 after release is granted first (ptr = 0 search, node 1 only requester).
